sim_run_ctrl: RTL and testbench

- Synthesizable run controller that sits between the simulation harness and riscv_top.
- Generates a parametrised core reset sequence (the btnC-style active-high reset into the core) and counts run cycles.
- Snoops the core's IO write bus: writes to the putc address queue characters in a FIFO; a write to the halt address ends the run.
- A timeout watchdog replaces the harness's fixed-delay finish. done, timeout and exit_code give the harness a deterministic end-of-run indication.

---
 rtl/sim_ctrl_pkg.sv | 21 ++
 rtl/sim_run_ctrl_if.sv | 29 ++
 rtl/sim_char_fifo.sv | 49 ++++
 rtl/sim_run_ctrl.sv | 127 ++++++++++++
 tb/tb_sim_run_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/sim_ctrl_pkg.sv
// Shared types and constants for the simulation run controller.
// Holds the run-state encoding, default IO addresses and a width helper.
package sim_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

  localparam logic [31:0] DEF_PUTC_ADDR = 32'h0003_0000;
  localparam logic [31:0] DEF_HALT_ADDR = 32'h0003_0004;

  function automatic int clog2(input int value);
    int result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/sim_run_ctrl_if.sv
// Harness-facing bundle: core IO write snoop, character stream and run status.
// master drives the core write strobe and char_ready; slave is the run controller.
interface sim_run_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              io_wr;
  logic [ADDR_W-1:0] io_addr;
  logic [7:0]        io_wdata;
  logic              char_valid;
  logic [7:0]        char_data;
  logic              char_ready;
  logic              cpu_rst;
  logic              done;
  logic              timeout;
  logic [7:0]        exit_code;
  logic [CNT_W-1:0]  cycle_count;
  logic              overflow;

  modport master (
    output io_wr, io_addr, io_wdata, char_ready,
    input  char_valid, char_data, cpu_rst, done, timeout, exit_code, cycle_count, overflow
  );

  modport slave (
    input  io_wr, io_addr, io_wdata, char_ready,
    output char_valid, char_data, cpu_rst, done, timeout, exit_code, cycle_count, overflow
  );
endinterface

// File: rtl/sim_char_fifo.sv
// First-word fall-through byte FIFO; a push is visible at o_head one cycle later.
// A push while full is accepted only if a pop happens on the same edge.
module sim_char_fifo
  import sim_ctrl_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  logic [7:0]  i_push_dat,
  input  logic        i_pop,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_count,
  output logic [7:0]  o_head
);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = o_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller: core reset sequencing, IO write snoop (putc/halt), watchdog and run cycle count.
// cpu_rst releases RST_CYCLES edges after rst_n; done rises once the char FIFO has drained after the run ends.
module sim_run_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int              RST_CYCLES     = 25,
  parameter int              TIMEOUT_CYCLES = 150000000,
  parameter int              CNT_W          = 32,
  parameter int              ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] PUTC_ADDR    = ADDR_W'(DEF_PUTC_ADDR),
  parameter logic [ADDR_W-1:0] HALT_ADDR    = ADDR_W'(DEF_HALT_ADDR),
  parameter int              FIFO_DEPTH     = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  sim_run_ctrl_if.slave  bus
);

  localparam int AW = clog2(FIFO_DEPTH);

  localparam logic [1:0] S_HOLD  = HOLD;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_FIN   = FIN;

  logic [1:0]       r_state;
  logic [31:0]      r_hold_cnt;
  logic             r_cpu_rst;
  logic             r_done;
  logic             r_timeout;
  logic             r_overflow;
  logic [7:0]       r_exit_code;
  logic [CNT_W-1:0] r_cycle_cnt;

  logic             w_run;
  logic             w_putc;
  logic             w_halt;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  logic             w_wdog;
  logic             w_drained;
  logic [AW:0]      w_count;
  logic [7:0]       w_head;
  logic [31:0]      w_hold_next;
  logic [CNT_W-1:0] w_cycle_next;

  assign w_run        = (r_state == S_RUN);
  assign w_putc       = w_run && bus.io_wr && (bus.io_addr == PUTC_ADDR);
  assign w_halt       = w_run && bus.io_wr && (bus.io_addr == HALT_ADDR);
  assign w_pop        = !w_empty && bus.char_ready;
  assign w_drop       = w_putc && w_full && !w_pop;
  assign w_hold_next  = r_hold_cnt + 32'd1;
  assign w_cycle_next = (&r_cycle_cnt) ? r_cycle_cnt : r_cycle_cnt + CNT_W'(1);
  assign w_wdog       = (w_cycle_next == CNT_W'(TIMEOUT_CYCLES));
  // Nothing is pushed outside RUN, so the FIFO is empty after this edge when its last entry pops.
  assign w_drained    = w_empty || ((w_count == (AW+1)'(1)) && w_pop);

  sim_char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_putc),
    .i_push_dat (bus.io_wdata),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count),
    .o_head     (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_HOLD;
      r_hold_cnt  <= '0;
      r_cpu_rst   <= 1'b1;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_overflow  <= 1'b0;
      r_exit_code <= '0;
      r_cycle_cnt <= '0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      case (r_state)
        S_HOLD: begin
          r_hold_cnt <= w_hold_next;
          if (w_hold_next >= 32'(RST_CYCLES)) begin
            r_cpu_rst <= 1'b0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          r_cycle_cnt <= w_cycle_next;
          // A halt on the watchdog edge takes priority, leaving timeout clear.
          if (w_halt) begin
            r_exit_code <= bus.io_wdata;
            r_cpu_rst   <= 1'b1;
            r_state     <= S_DRAIN;
          end else if (w_wdog) begin
            r_timeout <= 1'b1;
            r_cpu_rst <= 1'b1;
            r_state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_drained) begin
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cpu_rst     = r_cpu_rst;
  assign bus.char_valid  = !w_empty;
  assign bus.char_data   = w_head;
  assign bus.done        = r_done;
  assign bus.timeout     = r_timeout;
  assign bus.exit_code   = r_exit_code;
  assign bus.cycle_count = r_cycle_cnt;
  assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: reset sequence, putc stream/overflow table, halt drain and watchdog.
module tb_sim_run_ctrl;

  localparam logic [31:0] A_PUTC  = 32'h0003_0000;
  localparam logic [31:0] A_HALT  = 32'h0003_0004;
  localparam logic [31:0] A_OTHER = 32'h0003_0008;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sim_run_ctrl_if #(.ADDR_W(32), .CNT_W(32)) bus ();

  sim_run_ctrl #(
    .RST_CYCLES     (25),
    .TIMEOUT_CYCLES (100),
    .CNT_W          (32),
    .ADDR_W         (32),
    .PUTC_ADDR      (A_PUTC),
    .HALT_ADDR      (A_HALT),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic        rdy;
    logic        vld;
    logic [7:0]  dat;
    logic        ovf;
  } vec_t;

  vec_t vecs [16];
  int   passed = 0;
  int   total  = 0;
  int   early;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [31:0] addr, input logic [7:0] wdata, input logic rdy);
    bus.io_wr      = wr;
    bus.io_addr    = addr;
    bus.io_wdata   = wdata;
    bus.char_ready = rdy;
  endtask

  task automatic reset_and_boot();
    drive(1'b0, 32'h0, 8'h00, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (25) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got running, expected finished");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, A_PUTC,  8'h48, 1'b1, 1'b1, 8'h48, 1'b0};
    vecs[1]  = '{1'b1, A_PUTC,  8'h69, 1'b1, 1'b1, 8'h69, 1'b0};
    vecs[2]  = '{1'b1, A_PUTC,  8'h0A, 1'b1, 1'b1, 8'h0A, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,   8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, A_PUTC,  8'h41, 1'b0, 1'b1, 8'h41, 1'b0};
    vecs[5]  = '{1'b1, A_PUTC,  8'h42, 1'b0, 1'b1, 8'h41, 1'b0};
    vecs[6]  = '{1'b1, A_PUTC,  8'h43, 1'b0, 1'b1, 8'h41, 1'b0};
    vecs[7]  = '{1'b1, A_PUTC,  8'h44, 1'b0, 1'b1, 8'h41, 1'b0};
    vecs[8]  = '{1'b1, A_PUTC,  8'h45, 1'b1, 1'b1, 8'h42, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,   8'h00, 1'b0, 1'b1, 8'h42, 1'b0};
    vecs[10] = '{1'b1, A_PUTC,  8'h46, 1'b0, 1'b1, 8'h42, 1'b1};
    vecs[11] = '{1'b0, 32'h0,   8'h00, 1'b1, 1'b1, 8'h43, 1'b1};
    vecs[12] = '{1'b0, 32'h0,   8'h00, 1'b1, 1'b1, 8'h44, 1'b1};
    vecs[13] = '{1'b0, 32'h0,   8'h00, 1'b1, 1'b1, 8'h45, 1'b1};
    vecs[14] = '{1'b0, 32'h0,   8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[15] = '{1'b1, A_OTHER, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b1};

    // Reset values and the core reset sequence; putc writes during HOLD must be dropped.
    drive(1'b0, 32'h0, 8'h00, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_cpu_rst", bus.cpu_rst, 1);
    check("rst_done", bus.done, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_exit_code", bus.exit_code, 0);
    check("rst_cycle_count", bus.cycle_count, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_char_valid", bus.char_valid, 0);
    check("rst_char_data", bus.char_data, 0);
    rst_n = 1'b1;
    drive(1'b1, A_PUTC, 8'h51, 1'b0);
    early = 0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (bus.cpu_rst !== 1'b1) early++;
    end
    drive(1'b0, 32'h0, 8'h00, 1'b0);
    check("hold_edges_cpu_rst_low", early, 0);
    tick();
    check("edge25_cpu_rst", bus.cpu_rst, 0);
    check("edge25_cycle_count", bus.cycle_count, 0);
    check("hold_putc_ignored", bus.char_valid, 0);
    tick();
    check("run_cycle_count_1", bus.cycle_count, 1);

    // Putc stream, full-with-pop, overflow and foreign address, one vector per edge.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdy);
      tick();
      check($sformatf("vec%0d_char_valid", i), bus.char_valid, vecs[i].vld);
      check($sformatf("vec%0d_char_data", i), bus.char_data, vecs[i].dat);
      check($sformatf("vec%0d_overflow", i), bus.overflow, vecs[i].ovf);
      check($sformatf("vec%0d_rst_done_to", i), {bus.cpu_rst, bus.done, bus.timeout}, 0);
    end
    check("vec_cycle_count", bus.cycle_count, 17);

    // Halt with two characters pending; done waits for the last pop.
    reset_and_boot();
    check("boot2_overflow_cleared", bus.overflow, 0);
    check("boot2_fifo_empty", bus.char_valid, 0);
    drive(1'b1, A_PUTC, 8'h78, 1'b0);
    tick();
    drive(1'b1, A_PUTC, 8'h79, 1'b0);
    tick();
    drive(1'b1, A_HALT, 8'h07, 1'b0);
    tick();
    check("halt_exit_code", bus.exit_code, 8'h07);
    check("halt_cpu_rst", bus.cpu_rst, 1);
    check("halt_done", bus.done, 0);
    check("halt_head", bus.char_data, 8'h78);
    check("halt_cycle_count", bus.cycle_count, 3);
    drive(1'b1, A_PUTC, 8'h71, 1'b0);
    tick();
    check("drain_done_held", bus.done, 0);
    check("drain_cycle_frozen", bus.cycle_count, 3);
    drive(1'b0, 32'h0, 8'h00, 1'b1);
    tick();
    check("drain_pop1_done", bus.done, 0);
    check("drain_pop1_head", bus.char_data, 8'h79);
    tick();
    check("drain_last_pop_done", bus.done, 1);
    check("drain_last_pop_empty", bus.char_valid, 0);
    tick();
    check("fin_done", bus.done, 1);
    check("fin_exit_code", bus.exit_code, 8'h07);
    check("fin_timeout", bus.timeout, 0);
    check("fin_cycle_count", bus.cycle_count, 3);

    // Watchdog expiry, then an asynchronous reset out of FIN.
    reset_and_boot();
    repeat (99) tick();
    check("wdog_pre_count", bus.cycle_count, 99);
    check("wdog_pre_timeout", bus.timeout, 0);
    check("wdog_pre_cpu_rst", bus.cpu_rst, 0);
    tick();
    check("wdog_count", bus.cycle_count, 100);
    check("wdog_timeout", bus.timeout, 1);
    check("wdog_cpu_rst", bus.cpu_rst, 1);
    check("wdog_done_not_yet", bus.done, 0);
    tick();
    check("wdog_done", bus.done, 1);
    check("wdog_count_frozen", bus.cycle_count, 100);
    rst_n = 1'b0;
    #1;
    check("abort_cpu_rst", bus.cpu_rst, 1);
    check("abort_done", bus.done, 0);
    check("abort_timeout", bus.timeout, 0);
    check("abort_exit_code", bus.exit_code, 0);
    check("abort_cycle_count", bus.cycle_count, 0);
    check("abort_overflow", bus.overflow, 0);
    check("abort_char_valid", bus.char_valid, 0);

    // Halt on the same edge the watchdog would fire.
    reset_and_boot();
    repeat (99) tick();
    drive(1'b1, A_HALT, 8'h5A, 1'b0);
    tick();
    drive(1'b0, 32'h0, 8'h00, 1'b0);
    check("race_timeout", bus.timeout, 0);
    check("race_exit_code", bus.exit_code, 8'h5A);
    check("race_cpu_rst", bus.cpu_rst, 1);
    check("race_cycle_count", bus.cycle_count, 100);
    tick();
    check("race_done", bus.done, 1);
    check("race_timeout_after", bus.timeout, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
